// File: rtl/comparador_pkg.sv
// Shared types and helpers for the coin-accumulating price comparator.
package comparador_pkg;

  // Controller states; the numeric values are fixed so traces stay readable.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACUMULA = 3'd1,
    LIBERA  = 3'd2,
    TROCO   = 3'd3,
    DEVOLVE = 3'd4
  } estado_t;

  // Default table: eight 6-bit slots, all zero (every slot unavailable).
  localparam logic [47:0] PRECOS_PADRAO = {8{6'd0}};

  // Widest flattened table the extraction helper accepts.
  localparam int LARGURA_TABELA_MAX = 512;

  // Returns slot 'indice' of a flattened table whose slots are 'largura' bits wide.
  function automatic logic [31:0] extrai_preco(
    input logic [LARGURA_TABELA_MAX-1:0] tabela,
    input int unsigned                   indice,
    input int unsigned                   largura
  );
    logic [LARGURA_TABELA_MAX-1:0] deslocada;
    deslocada = tabela >> (indice * largura);
    return deslocada[31:0] & ((32'd1 << largura) - 32'd1);
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Inactivity counter: flags the cycle on which TIMEOUT enabled cycles have elapsed.
module contador_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expirou
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT - 1);
  localparam logic [W-1:0] TETO   = W'(TIMEOUT);

  logic [W-1:0] contagem;

  // Count enabled cycles; clear wins over enable, and the count never passes TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) begin
      contagem <= '0;
    end else if (clear) begin
      contagem <= '0;
    end else if (enable && (contagem != TETO)) begin
      contagem <= contagem + 1'b1;
    end
  end

  // Asserted during the idle cycle that completes the TIMEOUT-th count.
  assign expirou = enable && (contagem == LIMITE);

endmodule

// File: rtl/comparador_troco.sv
// Vending-machine controller: accumulates coins, checks a selection against
// the price table, dispenses, and pays change or refunds one unit per cycle.
module comparador_troco
  import comparador_pkg::*;
#(
  parameter int LARGURA_VALOR = 6,
  parameter int NUM_PRODUTOS  = 8,
  parameter int LARGURA_PROD  = 3,
  parameter logic [NUM_PRODUTOS*LARGURA_VALOR-1:0] PRECOS =
    (NUM_PRODUTOS*LARGURA_VALOR)'(PRECOS_PADRAO),
  parameter int TIMEOUT       = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     moedaValida,
  input  logic [LARGURA_VALOR-1:0] valorMoeda,
  input  logic                     selecionar,
  input  logic [LARGURA_PROD-1:0]  produto,
  input  logic                     cancelar,
  output logic [LARGURA_VALOR-1:0] valorTotal,
  output logic                     liberarProduto,
  output logic                     pulsoTroco,
  output logic                     devolverMoedas,
  output logic                     moedaRejeitada,
  output logic                     erroProduto,
  output logic                     ocupado,
  output logic                     fim
);

  localparam logic [LARGURA_VALOR-1:0] UM = LARGURA_VALOR'(1);

  estado_t                  estado, estado_n;
  logic [LARGURA_VALOR-1:0] valor_n;
  logic [LARGURA_VALOR:0]   soma;
  logic [LARGURA_VALOR-1:0] preco;
  logic                     produto_valido;
  logic                     aceito;
  logic                     rejeita_n, erro_n, fim_n;
  logic                     conta, limpa, expirou;

  // One extra bit on the sum detects overflow instead of wrapping.
  assign soma  = {1'b0, valorTotal} + {1'b0, valorMoeda};
  assign preco = LARGURA_VALOR'(extrai_preco(LARGURA_TABELA_MAX'(PRECOS),
                                             32'(produto), LARGURA_VALOR));
  assign produto_valido = (int'(produto) < NUM_PRODUTOS) && (preco != '0);

  // Inactivity only matters while holding a nonzero balance in ACUMULA.
  assign conta = (estado == ACUMULA) && (valorTotal != '0);
  assign limpa = (estado != ACUMULA) || aceito;

  contador_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (limpa),
    .enable  (conta),
    .expirou (expirou)
  );

  // Next-state, next-balance and strobe arbitration (cancelar > selecionar > moeda).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    estado_n  = estado;
    valor_n   = valorTotal;
    aceito    = 1'b0;
    rejeita_n = 1'b0;
    erro_n    = 1'b0;
    fim_n     = 1'b0;
    unique case (estado)
      IDLE, ACUMULA: begin
        if (cancelar) begin
          // Cancel wins arbitration; it only refunds when there is something to return.
          aceito    = 1'b1;
          rejeita_n = moedaValida;
          if ((estado == ACUMULA) && (valorTotal != '0)) estado_n = DEVOLVE;
        end else if (selecionar) begin
          aceito    = 1'b1;
          rejeita_n = moedaValida;
          if (!produto_valido || (valorTotal < preco)) begin
            erro_n = 1'b1;
          end else begin
            estado_n = LIBERA;
            valor_n  = valorTotal - preco;
          end
        end else if (moedaValida) begin
          if (!soma[LARGURA_VALOR]) begin
            aceito   = 1'b1;
            valor_n  = soma[LARGURA_VALOR-1:0];
            estado_n = ACUMULA;
          end else begin
            rejeita_n = 1'b1;
          end
        end
        // User activity in the expiry cycle keeps the session alive.
        if (!aceito && expirou) estado_n = DEVOLVE;
      end
      LIBERA: begin
        rejeita_n = moedaValida;
        if (valorTotal != '0) begin
          estado_n = TROCO;
        end else begin
          estado_n = IDLE;
          fim_n    = 1'b1;
        end
      end
      TROCO, DEVOLVE: begin
        // The unit shown this cycle is paid; leave when the last one goes out.
        rejeita_n = moedaValida;
        if (valorTotal > UM) begin
          valor_n = valorTotal - UM;
        end else begin
          valor_n  = '0;
          estado_n = IDLE;
          fim_n    = 1'b1;
        end
      end
      default: estado_n = IDLE;
    endcase
  end

  // State, balance and every output are registered; level outputs follow the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado         <= IDLE;
      valorTotal     <= '0;
      liberarProduto <= 1'b0;
      pulsoTroco     <= 1'b0;
      devolverMoedas <= 1'b0;
      moedaRejeitada <= 1'b0;
      erroProduto    <= 1'b0;
      ocupado        <= 1'b0;
      fim            <= 1'b0;
    end else begin
      estado         <= estado_n;
      valorTotal     <= valor_n;
      liberarProduto <= (estado_n == LIBERA);
      pulsoTroco     <= (estado_n == TROCO) || (estado_n == DEVOLVE);
      devolverMoedas <= (estado_n == DEVOLVE);
      moedaRejeitada <= rejeita_n;
      erroProduto    <= erro_n;
      ocupado        <= (estado_n == LIBERA) || (estado_n == TROCO) || (estado_n == DEVOLVE);
      fim            <= fim_n;
    end
  end

endmodule

// File: tb/tb_comparador_troco.sv
// Bench for comparador_troco: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_comparador_troco;

  localparam int LV      = 6;
  localparam int TIMEOUT = 20;
  localparam int MAXV    = (1 << LV) - 1;

  logic          clk, reset;
  logic          moedaValida, selecionar, cancelar;
  logic [LV-1:0] valorMoeda;
  logic [2:0]    produto;
  logic [LV-1:0] valorTotal;
  logic          liberarProduto, pulsoTroco, devolverMoedas;
  logic          moedaRejeitada, erroProduto, ocupado, fim;
  logic [6:0]    saidas_dut;

  int n_checks = 0;
  int n_fail   = 0;

  // Prices as the user sees them: slot 1 = 2, slot 3 = 5, slot 5 = 7.
  int precos [8] = '{0, 2, 0, 5, 0, 7, 0, 0};

  comparador_troco #(
    .LARGURA_VALOR (LV),
    .NUM_PRODUTOS  (8),
    .LARGURA_PROD  (3),
    .PRECOS        ({6'd0, 6'd0, 6'd7, 6'd0, 6'd5, 6'd0, 6'd2, 6'd0}),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .moedaValida    (moedaValida),
    .valorMoeda     (valorMoeda),
    .selecionar     (selecionar),
    .produto        (produto),
    .cancelar       (cancelar),
    .valorTotal     (valorTotal),
    .liberarProduto (liberarProduto),
    .pulsoTroco     (pulsoTroco),
    .devolverMoedas (devolverMoedas),
    .moedaRejeitada (moedaRejeitada),
    .erroProduto    (erroProduto),
    .ocupado        (ocupado),
    .fim            (fim)
  );

  assign saidas_dut = {liberarProduto, pulsoTroco, devolverMoedas,
                       moedaRejeitada, erroProduto, ocupado, fim};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nome, input int atual, input int esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nome, $time, atual, esperado);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_saldo;
  int m_ocioso;
  bit m_sessao, m_libera, m_paga, m_devolve;
  bit m_rej, m_erro, m_fim;

  task automatic modelo_reset();
    m_saldo = 0; m_ocioso = 0;
    m_sessao = 0; m_libera = 0; m_paga = 0; m_devolve = 0;
    m_rej = 0; m_erro = 0; m_fim = 0;
  endtask

  task automatic modelo_passo();
    bit ativo;
    int preco;
    m_rej = 0; m_erro = 0; m_fim = 0;
    if (m_paga) begin
      m_rej = moedaValida;
      m_saldo--;
      if (m_saldo == 0) begin
        m_paga = 0; m_devolve = 0; m_fim = 1;
      end
    end else if (m_libera) begin
      m_rej    = moedaValida;
      m_libera = 0;
      if (m_saldo > 0) m_paga = 1;
      else             m_fim  = 1;
    end else begin
      ativo = 0;
      if (cancelar) begin
        ativo = 1;
        m_rej = moedaValida;
        if (m_sessao && m_saldo > 0) begin
          m_paga = 1; m_devolve = 1; m_sessao = 0;
        end
      end else if (selecionar) begin
        ativo = 1;
        m_rej = moedaValida;
        preco = precos[produto];
        if (preco == 0 || m_saldo < preco) begin
          m_erro = 1;
        end else begin
          m_saldo  = m_saldo - preco;
          m_libera = 1;
          m_sessao = 0;
        end
      end else if (moedaValida) begin
        if (m_saldo + int'(valorMoeda) <= MAXV) begin
          ativo    = 1;
          m_saldo  = m_saldo + int'(valorMoeda);
          m_sessao = 1;
        end else begin
          m_rej = 1;
        end
      end
      if (ativo || !m_sessao || m_saldo == 0) begin
        m_ocioso = 0;
      end else begin
        m_ocioso++;
        if (m_ocioso == TIMEOUT) begin
          m_paga = 1; m_devolve = 1; m_sessao = 0; m_ocioso = 0;
        end
      end
    end
  endtask

  function automatic logic [6:0] saidas_modelo();
    return {m_libera, m_paga, m_paga && m_devolve, m_rej, m_erro,
            m_libera || m_paga, m_fim};
  endfunction

  // Single compare process: advance the model at each edge, check just after it.
  always @(posedge clk) begin
    if (reset) modelo_reset();
    else       modelo_passo();
    #1;
    if (!reset) begin
      check("modelo valorTotal", int'(valorTotal), m_saldo);
      check("modelo saidas", int'(saidas_dut), int'(saidas_modelo()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic zera_entradas();
    moedaValida = 0; valorMoeda = '0; selecionar = 0; produto = '0; cancelar = 0;
  endtask

  task automatic ciclo(input logic mv, input int vm, input logic sel,
                       input int prod, input logic canc);
    @(negedge clk);
    moedaValida = mv;
    valorMoeda  = LV'(vm);
    selecionar  = sel;
    produto     = 3'(prod);
    cancelar    = canc;
    @(posedge clk);
    #2;
    zera_entradas();
  endtask

  task automatic moeda(input int v);
    ciclo(1, v, 0, 0, 0);
  endtask

  task automatic ocioso();
    ciclo(0, 0, 0, 0, 0);
  endtask

  // Counts pulses from the current cycle until fim, bounded.
  task automatic drena(output int pulsos, output int devolvidos, output int terminou);
    pulsos = 0; devolvidos = 0; terminou = 0;
    for (int i = 0; i < 100; i++) begin
      if (fim) begin
        terminou = 1;
        break;
      end
      pulsos     += int'(pulsoTroco);
      devolvidos += int'(devolverMoedas);
      ocioso();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, d, t, n, silencio;
    reset = 1'b1;
    zera_entradas();
    repeat (3) @(posedge clk);
    #1;
    check("reset valorTotal", int'(valorTotal), 0);
    check("reset saidas", int'(saidas_dut), 0);
    @(negedge clk);
    reset = 1'b0;

    // Coins 2,2,2 then product 3 (price 5): dispense, one unit of change.
    moeda(2);            check("A saldo 2", int'(valorTotal), 2);
    moeda(2); moeda(2);  check("A saldo 6", int'(valorTotal), 6);
    ciclo(0, 0, 1, 3, 0);
    check("A liberar", int'(liberarProduto), 1);
    check("A saldo apos compra", int'(valorTotal), 1);
    ocioso();
    check("A troco pulso", int'(pulsoTroco), 1);
    check("A troco sem devolver", int'(devolverMoedas), 0);
    ocioso();
    check("A fim", int'(fim), 1);
    check("A saldo final", int'(valorTotal), 0);
    check("A livre", int'(ocupado), 0);

    // Insufficient balance, then an exact purchase with no change.
    moeda(2);
    ciclo(0, 0, 1, 5, 0);
    check("B erro saldo", int'(erroProduto), 1);
    check("B saldo mantido", int'(valorTotal), 2);
    moeda(5);            check("B saldo 7", int'(valorTotal), 7);
    ciclo(0, 0, 1, 5, 0);
    check("B liberar", int'(liberarProduto), 1);
    ocioso();
    check("B fim", int'(fim), 1);
    check("B sem troco", int'(pulsoTroco), 0);

    // Unavailable slot keeps the balance; cancel refunds all of it.
    moeda(4);
    ciclo(0, 0, 1, 2, 0);
    check("C erro slot", int'(erroProduto), 1);
    check("C saldo 4", int'(valorTotal), 4);
    ciclo(0, 0, 0, 0, 1);
    drena(p, d, t);
    check("C pulsos", p, 4);
    check("C devolver ciclos", d, 4);
    check("C terminou", t, 1);

    // Cancel and select together: refund wins.
    moeda(3); moeda(1);
    ciclo(0, 0, 1, 1, 1);
    check("D sem liberar", int'(liberarProduto), 0);
    check("D devolvendo", int'(devolverMoedas), 1);
    drena(p, d, t);
    check("D pulsos", p, 4);
    check("D devolver ciclos", d, 4);

    // Inactivity: refund starts after exactly TIMEOUT idle cycles.
    moeda(4);
    n = 0;
    while (!devolverMoedas && n < 60) begin
      ocioso();
      n++;
    end
    check("E ciclos ate timeout", n, 20);
    drena(p, d, t);
    check("E pulsos", p, 4);

    // Coin during change is rejected and does not touch the balance.
    moeda(6);
    ciclo(0, 0, 1, 1, 0);
    check("F saldo 4", int'(valorTotal), 4);
    ocioso();
    moeda(3);
    check("F moeda rejeitada", int'(moedaRejeitada), 1);
    check("F saldo 3", int'(valorTotal), 3);
    drena(p, d, t);
    check("F pulsos restantes", p, 3);
    check("F terminou", t, 1);

    // Overflow rejected without saturating; exact maximum accepted.
    moeda(20); moeda(20); moeda(20);
    check("G saldo 60", int'(valorTotal), 60);
    moeda(5);
    check("G overflow rejeitado", int'(moedaRejeitada), 1);
    check("G saldo 60 mantido", int'(valorTotal), 60);
    moeda(3);
    check("G saldo maximo", int'(valorTotal), 63);
    ciclo(0, 0, 1, 5, 0);
    check("G saldo 56", int'(valorTotal), 56);
    ocioso();
    check("G em troco", int'(pulsoTroco), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("G reset saldo", int'(valorTotal), 0);
    check("G reset saidas", int'(saidas_dut), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ocioso();
    check("G apos reset livre", int'(ocupado), 0);

    // Randomized traffic; the compare process does the checking.
    silencio = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) < 2);
      if (silencio > 0) begin
        zera_entradas();
        silencio--;
      end else begin
        if ($urandom_range(0, 99) < 2) silencio = int'($urandom_range(10, 26));
        moedaValida = ($urandom_range(0, 99) < 35);
        valorMoeda  = ($urandom_range(0, 9) == 0) ? LV'($urandom_range(0, 63))
                                                  : LV'($urandom_range(0, 8));
        selecionar  = ($urandom_range(0, 99) < 10);
        produto     = 3'($urandom_range(0, 7));
        cancelar    = ($urandom_range(0, 99) < 3);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    zera_entradas();
    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comparador_troco.md
Name: comparador_troco

Overview:
- Sequential successor to the combinational price comparator in the vending machine.
- Accumulates inserted coins and accepts a product selection, then compares the balance against a parametrised price table.
- On success it releases the product and returns the difference as change, one coin unit per cycle. Cancel and inactivity timeout refund the full balance.
- Sits between the coin-input debouncer and the dispenser/change-hopper drivers.

Parameters:
- LARGURA_VALOR, 6: width of coin, price and balance values (in coin units).
- NUM_PRODUTOS, 8: number of product slots.
- LARGURA_PROD, 3: width of the product index; must satisfy 2**LARGURA_PROD >= NUM_PRODUTOS.
- PRECOS, {8{6'd0}} overridden at top: flattened price table, NUM_PRODUTOS*LARGURA_VALOR bits, slot i at bits [i*LARGURA_VALOR +: LARGURA_VALOR]. Price 0 means slot unavailable.
- TIMEOUT, 1000: idle cycles with nonzero balance before an automatic refund. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- moedaValida  input  1  one-cycle strobe: a coin was inserted.
- valorMoeda  input  LARGURA_VALOR  value of the coin; sampled only when moedaValida=1.
- selecionar  input  1  one-cycle strobe: the user selected a product.
- produto  input  LARGURA_PROD  product index; sampled only when selecionar=1.
- cancelar  input  1  one-cycle strobe: refund request.
- valorTotal  output  LARGURA_VALOR  current balance, registered.
- liberarProduto  output  1  one-cycle pulse: dispense the selected product.
- pulsoTroco  output  1  one pulse per coin unit returned (change or refund).
- devolverMoedas  output  1  high throughout a refund (cancel or timeout); low during normal change.
- moedaRejeitada  output  1  one-cycle pulse: the coin was not accepted.
- erroProduto  output  1  one-cycle pulse: invalid slot, or insufficient balance.
- ocupado  output  1  high in LIBERA, TROCO and DEVOLVE.
- fim  output  1  one-cycle pulse on return to IDLE after any completed transaction.

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0: valorTotal=0, timeout counter=0, all pulses low. Reset mid-transaction abandons the transaction with no further pulses.
- States: IDLE, ACUMULA, LIBERA, TROCO, DEVOLVE.
- Input priority in the same cycle, IDLE/ACUMULA only: cancelar > selecionar > moedaValida. A lower-priority strobe in the same cycle is dropped. A dropped coin pulses moedaRejeitada.
- Coin handling, IDLE/ACUMULA:
  - If valorTotal+valorMoeda <= 2**LARGURA_VALOR-1, balance updates next cycle and state goes to ACUMULA.
  - Otherwise the balance is unchanged and moedaRejeitada pulses next cycle. Never wrap; never saturate.
  - A coin with value 0 is accepted as a no-op, but still resets the timeout counter.
- Coins in LIBERA, TROCO or DEVOLVE: moedaRejeitada pulses; the coin is not added.
- selecionar in IDLE/ACUMULA: preco = PRECOS slot[produto].
  - produto >= NUM_PRODUTOS or preco == 0: erroProduto pulses; state and balance unchanged.
  - valorTotal < preco: erroProduto pulses; stay in the current state.
  - valorTotal >= preco: go to LIBERA; valorTotal <= valorTotal - preco on the same edge.
- LIBERA, exactly 1 cycle: liberarProduto=1. Next state is TROCO if valorTotal > 0, else IDLE with fim pulsed.
- TROCO: each cycle pulsoTroco=1 and valorTotal decrements by 1. On the cycle valorTotal reaches 0, go to IDLE and pulse fim. Change of N units takes N cycles.
- cancelar in ACUMULA with balance > 0: go to DEVOLVE.
- cancelar in IDLE or with balance 0: ignored.
- cancelar in LIBERA or TROCO: ignored.
- DEVOLVE: devolverMoedas=1. Otherwise identical to TROCO (one pulsoTroco per cycle down to 0, then IDLE and fim).
- Timeout, ACUMULA only:
  - The counter resets on any accepted strobe (coin, selection attempt, cancel).
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT, go to DEVOLVE.
  - The counter is cleared outside ACUMULA.
- Latency: all outputs are registered; the response appears on the cycle after the strobe.

Decomposition:
- Package comparador_pkg holds:
  - the state encoding localparams (IDLE=0, ACUMULA=1, LIBERA=2, TROCO=3, DEVOLVE=4);
  - the default price table;
  - a function that extracts a price from the flattened table.
- One natural sub-module: contador_timeout. It takes clk, reset, clear and enable, and outputs expirou; it is parametrised by TIMEOUT.

Test Plan (PRECOS slot1=2, slot3=5, slot5=7; others 0; TIMEOUT=20):
- Coins 2,2,2, then select produto=3 -> liberarProduto 1 cycle, then 1 pulsoTroco, fim, valorTotal=0.
- Coins 2, then select produto=5 -> erroProduto, state ACUMULA, valorTotal=2. Add coin 5, then select 5 -> liberarProduto, 0 pulsoTroco, fim.
- Select produto=2 (price 0) with balance 4 -> erroProduto; balance 4 retained.
- Coins 3,1, then cancelar -> devolverMoedas high 4 cycles, 4 pulsoTroco, fim. Same scenario with cancelar and selecionar in the same cycle -> refund wins; no liberarProduto.
- Coin 4, then no activity 20 cycles -> DEVOLVE, 4 pulsoTroco. Coin inserted during TROCO -> moedaRejeitada; balance unaffected.
- Balance 60, coin 5 -> moedaRejeitada, balance 60. Assert reset during TROCO -> all outputs 0 immediately, state IDLE.
